// File: rtl/logic_pod_change_compressor.sv
// logic_pod_change_compressor
// Forwards only the 8-lane x 20-sample blocks that contain a transition,
// each tagged with the cycle timestamp at which it was sampled. A keyframe
// record opens every contiguous segment, and keepalive records bound the gap
// between emitted records to MAX_IDLE cycles. Records leave through a small
// first-word-fall-through FIFO with a valid/ready handshake.
//
// Build option: define LOGIC_POD_COMPRESS_STATS_EN to add the saturating
// stat_emitted / stat_dropped counters and their output ports.
module logic_pod_change_compressor #(
  parameter int TS_WIDTH   = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_IDLE   = 1024
) (
  input  logic                clk_250mhz,
  input  logic                rst,
  input  logic                en,
  input  logic [159:0]        samples,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [TS_WIDTH-1:0] out_timestamp,
  output logic [159:0]        out_data,
  output logic                out_keyframe,
  output logic                overflow
`ifdef LOGIC_POD_COMPRESS_STATS_EN
  ,
  output logic [31:0]         stat_emitted,
  output logic [31:0]         stat_dropped
`endif
);

  localparam int LANES  = 8;
  localparam int LANE_W = 20;
  localparam int DATA_W = LANES * LANE_W;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int IDLE_W = 16;
  // Record layout: {keyframe, timestamp, data}
  localparam int REC_W  = 1 + TS_WIDTH + DATA_W;

  // The state register sits alongside the stage-1 data, so it always
  // describes the enable history of the block currently in stage 2:
  // IDLE = block captured with en low, FIRST = first enabled block,
  // RUN = enabled block following another enabled block.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FIRST = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // Stage 1: timestamp counter, sample capture, enable tracking
  // ---------------------------------------------------------------------
  logic [TS_WIDTH-1:0] ts_q;
  logic [TS_WIDTH-1:0] s1_ts_q;
  logic [DATA_W-1:0]   s1_data_q;
  state_t              state_q;
  state_t              state_d;

  // Next enable state: any cycle with en low returns to IDLE.
  always_comb begin
    state_d = ST_IDLE;
    if (en) begin
      case (state_q)
        ST_IDLE:  state_d = ST_FIRST;
        ST_FIRST: state_d = ST_RUN;
        ST_RUN:   state_d = ST_RUN;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Free-running timestamp plus stage-1 capture of samples, ts and state.
  always_ff @(posedge clk_250mhz) begin
    if (rst) begin
      ts_q      <= '0;
      s1_ts_q   <= '0;
      s1_data_q <= '0;
      state_q   <= ST_IDLE;
    end else begin
      ts_q      <= ts_q + TS_WIDTH'(1);
      s1_ts_q   <= ts_q;
      s1_data_q <= samples;
      state_q   <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: change detection and emit decision
  // ---------------------------------------------------------------------
  logic [LANES-1:0]  lane_chg;
  logic [LANES-1:0]  lane_last;
  logic [LANES-1:0]  prev_last_q;
  logic [IDLE_W-1:0] idle_q;
  logic [IDLE_W-1:0] idle_d;
  logic              kf_pending_q;
  logic              overflow_q;
  logic              blk_en;
  logic              change;
  logic              keepalive;
  logic              emit;
  logic              push;
  logic              drop;
  logic              pop;
  logic              fifo_full;
  logic              push_kf;

  // Per-lane transition check: adjacent samples inside the block, plus the
  // boundary between the previous enabled block's last sample and bit 0.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [LANE_W-1:0] lane;
      assign lane          = s1_data_q[LANE_W*gi +: LANE_W];
      assign lane_last[gi] = lane[LANE_W-1];
      assign lane_chg[gi]  = (|(lane[LANE_W-2:0] ^ lane[LANE_W-1:1]))
                             | (lane[0] ^ prev_last_q[gi]);
    end
  endgenerate

  assign blk_en    = (state_q != ST_IDLE);
  assign change    = |lane_chg;
  assign keepalive = (idle_q == IDLE_W'(MAX_IDLE - 1));
  assign emit      = (state_q == ST_FIRST)
                     | ((state_q == ST_RUN) & (change | keepalive));

  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign pop       = out_valid & out_ready;
  assign push      = emit & (~fifo_full | pop);
  assign drop      = emit & fifo_full & ~pop;
  assign push_kf   = (state_q == ST_FIRST) | kf_pending_q;

  // Idle counter restarts on every emit attempt (a dropped record counts
  // too) and whenever the block in stage 2 was captured with en low.
  always_comb begin
    idle_d = idle_q + IDLE_W'(1);
    if (!blk_en || emit) begin
      idle_d = '0;
    end
  end

  // Stage-2 state: idle count, boundary history, drop tracking.
  always_ff @(posedge clk_250mhz) begin
    if (rst) begin
      idle_q       <= '0;
      prev_last_q  <= '0;
      kf_pending_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      idle_q <= idle_d;
      if (blk_en) begin
        prev_last_q <= lane_last;
      end
      if (drop) begin
        overflow_q   <= 1'b1;
        kf_pending_q <= 1'b1;
      end else if (push) begin
        kf_pending_q <= 1'b0;
      end
    end
  end

  assign overflow = overflow_q;

  // ---------------------------------------------------------------------
  // Output FIFO (first-word-fall-through)
  // ---------------------------------------------------------------------
  logic [REC_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] rd_ptr_d;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [REC_W-1:0] head_rec;

  assign fifo_full = (count_q == CNT_W'(FIFO_DEPTH));

  // Pointer and occupancy update for push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO bookkeeping; reset discards any stored records.
  always_ff @(posedge clk_250mhz) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Record storage; contents are only meaningful below count_q.
  always_ff @(posedge clk_250mhz) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {push_kf, s1_ts_q, s1_data_q};
    end
  end

  // Head of the FIFO drives the outputs; they read zero while empty so the
  // port values are defined out of reset.
  assign head_rec      = fifo_mem[rd_ptr_q];
  assign out_valid     = (count_q != '0);
  assign out_data      = out_valid ? head_rec[DATA_W-1:0] : '0;
  assign out_timestamp = out_valid ? head_rec[DATA_W +: TS_WIDTH] : '0;
  assign out_keyframe  = out_valid & head_rec[REC_W-1];

`ifdef LOGIC_POD_COMPRESS_STATS_EN
  logic [31:0] stat_emitted_q;
  logic [31:0] stat_dropped_q;

  // Saturating counters of pushed and dropped records.
  always_ff @(posedge clk_250mhz) begin
    if (rst) begin
      stat_emitted_q <= '0;
      stat_dropped_q <= '0;
    end else begin
      if (push && (stat_emitted_q != 32'hFFFF_FFFF)) begin
        stat_emitted_q <= stat_emitted_q + 32'd1;
      end
      if (drop && (stat_dropped_q != 32'hFFFF_FFFF)) begin
        stat_dropped_q <= stat_dropped_q + 32'd1;
      end
    end
  end

  assign stat_emitted = stat_emitted_q;
  assign stat_dropped = stat_dropped_q;
`endif

endmodule

// File: doc/logic_pod_change_compressor.md
Name: logic_pod_change_compressor

Overview:
Downstream consumer of the 8-lane logic pod datapath output, running in the 250 MHz capture domain. Each cycle it receives one 20-sample block per lane (5 Gsps / 250 MHz) and forwards only blocks containing a transition, each tagged with a cycle timestamp. Keyframe and keepalive records keep the reconstructed waveform unambiguous. Records are buffered in a small first-word-fall-through (FWFT) FIFO toward the capture memory writer through a valid/ready interface.

Parameters:
TS_WIDTH, 32, width of the cycle timestamp counter; wraps modulo 2^TS_WIDTH
FIFO_DEPTH, 16, output FIFO depth in records; power of 2, minimum 4
MAX_IDLE, 1024, maximum number of cycles allowed between emitted records while enabled; range 2..2^16-1

Ports:
clk_250mhz  in  1  sole clock, same 250 MHz capture clock as the pod datapath
rst  in  1  synchronous reset, active-high
en  in  1  capture enable; compression runs only while high
samples  in  160  lane g occupies [20g+19:20g]; within a lane, bit 0 is the earliest sample
out_valid  out  1  record available
out_ready  in  1  consumer accepts the record when out_valid & out_ready
out_timestamp  out  TS_WIDTH  cycle count at which the block was sampled
out_data  out  160  the block, same layout as samples
out_keyframe  out  1  record starts a new contiguous segment
overflow  out  1  sticky; a record was dropped because the FIFO was full

Behaviour:
- Reset: out_valid=0, out_timestamp=0, out_data=0, out_keyframe=0, overflow=0. Also on reset: FIFO empty, ts counter=0, idle counter=0, prev_last=0, FSM in IDLE.
- ts counter: increments every cycle after reset, regardless of en; wraps to 0.
- Stage 1: register samples together with the current ts value.
- Stage 2: decide whether to emit, and push to the FIFO.
- Latency: a block presented at cycle N with the FIFO empty appears on out_* at cycle N+2 (FWFT).
- prev_last[7:0]: bit 19 of each lane from the previous enabled block.
- change: any lane has bit i != bit i+1 for i in 0..18, or bit 0 != prev_last.
- FSM:
  - IDLE: no emission. en=1 -> FIRST.
  - FIRST: emit the block with keyframe=1 unconditionally -> RUN.
  - RUN:
    - emit when change=1 (keyframe=0), or when idle counter reaches MAX_IDLE-1 (keepalive, keyframe=0).
    - idle counter clears on every emission and otherwise increments.
  - Any state: en=0 -> IDLE at the next cycle; idle counter cleared.
- en is evaluated in the same stage as its samples; en must be pipelined alongside the data.
- FIFO full at push: record dropped, overflow set (cleared only by rst). The next successfully pushed record is forced to keyframe=1, and idle counter is cleared as if emitted.
- Simultaneous push and pop on a full FIFO: the pop frees the slot and the push succeeds (no drop).
- out_* hold stable while out_valid=1 and out_ready=0.
- rst mid-operation: FIFO contents discarded; out_valid falls the cycle after rst is sampled.
- Blocks whose first sample appears while en=0 are never emitted, even if pipeline latency straddles the en edge.

Optional Feature:
LOGIC_POD_COMPRESS_STATS_EN:
- Defined: adds outputs stat_emitted[31:0] and stat_dropped[31:0]. These count records pushed and records dropped, saturate at 32'hFFFFFFFF, and reset to 0 on rst.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Constant 0 input, en rises at cycle 10, out_ready=1 -> keyframe record ts=10 (out_valid at cycle 12), then keepalives at ts=10+1024k, no other records.
- Constant 0, then lane 3 block = 20'h00010 at cycle 50 (en high since 10) -> one record ts=50, data[79:60]=20'h00010, keyframe=0; the following all-zero block (bit0=0 vs prev_last=0) is not emitted.
- Lane 0 all-ones block after all-zero blocks (boundary edge only) -> emitted; the next all-ones block is not emitted.
- out_ready=0, toggling input every cycle for 20 cycles with FIFO_DEPTH=16 -> 16 records held, overflow=1; out_ready=1 drains 16 records in order, and the next pushed record has keyframe=1.
- en drops at cycle 100 while toggling -> last record has ts=99, nothing emitted until en returns; the first record after return has keyframe=1.
- rst asserted while the FIFO holds 5 records -> out_valid=0 one cycle later, overflow=0; with STATS_EN, counters read 0.
